rr_mux_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32-bit resource port (for example the memory/bus port) between up to 4 requesters.
- Generates the 2-bit select that steers the datapath's 4:1 operand/address mux, plus a one-hot grant.
- Holds each grant until the resource signals completion, the requester withdraws, or a hold timeout expires.
- Sits between the pipeline-stage request logic and the shared-port 4:1 mux.

---
 rtl/rr_mux_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for one shared 32-bit resource port among four requesters.
// Drives a registered 4:1 mux select and a one-hot grant; grants are held until done, withdrawal or hold timeout.
module rr_mux_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [1:0]       sel,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               to_q, to_d;

  logic               hold_exp;
  logic               held;
  logic               rel;
  logic               to_only;
  logic [N_REQ-1:0]   cand;
  logic [1:0]         base;
  logic               arb;
  logic [2:0]         win;

  // Returns {found, index} of the first set bit scanning upward from base, wrapping.
  function automatic logic [2:0] pick(input logic [N_REQ-1:0] c, input logic [1:0] b);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = b + 2'(i);
      if (!r[2] && c[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign hold_exp = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign held     = req[sel_q];
  assign rel      = done | ~held | hold_exp;
  // A release counts as a timeout only when neither done nor withdrawal also applies.
  assign to_only  = hold_exp & ~done & held;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    to_d    = 1'b0;
    base    = ptr_q;
    cand    = req;
    arb     = 1'b0;
    unique case (state_q)
      IDLE: begin
        arb = |req;
      end
      GRANT: begin
        if (rel) begin
          arb   = 1'b1;
          base  = sel_q + 2'd1;
          ptr_d = base;
          to_d  = to_only;
          if (to_only) cand[sel_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    win = pick(cand, base);
    if (arb) begin
      if (win[2]) begin
        state_d = GRANT;
        sel_d   = win[1:0];
        gnt_d   = N_REQ'(1) << win[1:0];
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = (state_q == GRANT);
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: a cycle model feeds an expected-output queue,
// popped and compared after each edge, plus directed checks of the documented scenarios.
module tb_rr_mux_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  rr_mux_arbiter #(.N_REQ(4), .MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  bit m_busy;
  int m_ptr;
  int m_cnt;
  int m_k;
  bit m_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_cnt = 0; m_k = 0; m_to = 0;
  endtask

  function automatic int find_winner(input logic [3:0] c, input int start);
    for (int j = 0; j < 4; j++) begin
      if (c[(start + j) % 4]) return (start + j) % 4;
    end
    return -1;
  endfunction

  task automatic model_step();
    exp_t e;
    int w;
    bit expired, stay;
    logic [3:0] c;
    m_to = 0;
    if (!m_busy) begin
      if (req != 4'b0) begin
        w = find_winner(req, m_ptr);
        m_busy = 1; m_k = w; m_cnt = 0;
      end
    end else begin
      expired = (m_cnt == MH - 1);
      stay = !done && req[m_k] && !expired;
      if (stay) begin
        m_cnt++;
      end else begin
        m_to = expired && !done && req[m_k];
        m_ptr = (m_k + 1) % 4;
        c = req;
        if (m_to) c[m_k] = 1'b0;
        w = find_winner(c, m_ptr);
        if (w < 0) m_busy = 0;
        else begin m_k = w; m_cnt = 0; end
      end
    end
    e.gnt = m_busy ? (4'b0001 << m_k) : 4'b0000;
    e.sel = 2'(m_k);
    e.busy = m_busy;
    e.timeout = m_to;
    exp_q.push_back(e);
  endtask

  // One clock: predict, advance, then compare the DUT against the popped prediction.
  task automatic step();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_gnt", 32'(gnt), 32'(e.gnt));
      chk("sb_sel", 32'(sel), 32'(e.sel));
      chk("sb_busy", 32'(busy), 32'(e.busy));
      chk("sb_timeout", 32'(timeout), 32'(e.timeout));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    req  = 4'b0100;
    done = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt_async", 32'(gnt), 32'h0);
    chk("rst_busy_async", 32'(busy), 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    rst = 1'b1;
    step();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_sel", 32'(sel), 32'h2);
    chk("single_busy", 32'(busy), 32'h1);

    // Rotation with done every third cycle.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      done = (i % 3 == 2);
      step();
      chk("rot_busy", 32'(busy), 32'h1);
      chk("rot_sel", 32'(sel), 32'((i + 1) / 3 % 4));
    end
    done = 1'b0;

    // Fairness after skip.
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b1001; done = 1'b1;
    step(); chk("fair_g3", 32'(gnt), 32'h8);
    step(); chk("fair_g0", 32'(gnt), 32'h1);
    step(); chk("fair_g3b", 32'(gnt), 32'h8);
    done = 1'b0;

    // Hold timeout with a second requester waiting.
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < MH; i++) begin
      step();
      chk("to_hold", 32'(gnt), 32'h1);
    end
    step();
    chk("to_gnt", 32'(gnt), 32'h2);
    chk("to_pulse", 32'(timeout), 32'h1);
    step();
    chk("to_pulse_end", 32'(timeout), 32'h0);

    // Lone requester under timeout: one idle cycle, then re-granted.
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < MH; i++) step();
    step();
    chk("lone_idle_gnt", 32'(gnt), 32'h0);
    chk("lone_idle_to", 32'(timeout), 32'h1);
    step();
    chk("lone_regrant", 32'(gnt), 32'h1);

    // Withdrawal, then done while idle.
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b0000;
    step();
    chk("wd_gnt", 32'(gnt), 32'h0);
    chk("wd_busy", 32'(busy), 32'h0);
    chk("wd_to", 32'(timeout), 32'h0);
    done = 1'b1;
    step();
    chk("idle_done_gnt", 32'(gnt), 32'h0);
    done = 1'b0;
    req = 4'b1111;
    step();
    chk("wd_ptr3", 32'(gnt), 32'h8);

    // Asynchronous reset mid-grant.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    model_reset();
    rst = 1'b1;
    req = 4'b1001;
    step();
    chk("arst_ptr0", 32'(gnt), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
